// File: rtl/event_sched_pkg.sv
// Shared constants and the queued event record for the monitor ingress scheduler.
// EVENT_SCHED_TIMESTAMP_EN adds a 64-bit push timestamp to every queued event.
package event_sched_pkg;

   localparam int SCHED_STAGES = 5;
   localparam int SCHED_DEPTH  = 8;
   localparam int SCHED_INPUTS = 3;
   localparam int SCHED_DATA_W = 64;

   localparam int STAGE_W = $clog2(SCHED_STAGES);
   localparam int FILL_W  = $clog2(SCHED_DEPTH + 1);

   // LLC stage at which a queued event may be handed to the monitor
   localparam logic [STAGE_W-1:0] STAGE_ISSUE = '0;

   typedef struct packed {
`ifdef EVENT_SCHED_TIMESTAMP_EN
      logic [63:0]                            ts;
`endif
      logic [SCHED_INPUTS*SCHED_DATA_W-1:0]   data;
      logic [SCHED_INPUTS-1:0]                present;
   } event_t;

endpackage

// File: rtl/sched_fifo.sv
// Synchronous FIFO holding pending monitor events; head is visible combinationally.
// DEPTH must be a power of two so the pointers wrap on their own.
module sched_fifo
   import event_sched_pkg::*;
#(
   parameter int WIDTH = $bits(event_t),
   parameter int DEPTH = SCHED_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             wdata,
   input  logic                         pop,
   output logic [WIDTH-1:0]             rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   fill
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign fill    = count;
   assign rdata   = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; the pointers and count define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/event_scheduler.sv
// Ingress scheduler for the RTLola monitor: queues events, releases one per HLC period at LLC stage 0.
// EVENT_SCHED_TIMESTAMP_EN adds a free-running en-cycle counter and the ev_ts output.
module event_scheduler
   import event_sched_pkg::*;
#(
   parameter int NUM_STAGES = SCHED_STAGES,
   parameter int DEPTH      = SCHED_DEPTH,
   parameter int NUM_INPUTS = SCHED_INPUTS,
   parameter int DATA_W     = SCHED_DATA_W
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             en,
   input  logic                             ev_valid,
   output logic                             ev_ready,
   input  logic [NUM_INPUTS*DATA_W-1:0]     ev_data,
   input  logic [NUM_INPUTS-1:0]            ev_present,
   output logic [NUM_INPUTS*DATA_W-1:0]     out_data,
   output logic [NUM_INPUTS-1:0]            out_new,
   output logic                             out_tick,
   output logic [$clog2(NUM_STAGES)-1:0]    stage,
   output logic [$clog2(DEPTH+1)-1:0]       fill
`ifdef EVENT_SCHED_TIMESTAMP_EN
   ,
   output logic [63:0]                      ev_ts
`endif
);

   localparam int ST_W = $clog2(NUM_STAGES);

   event_t wr_ev;
   event_t head_ev;
   logic   full;
   logic   empty;
   logic   issue;

   assign wr_ev.data    = ev_data;
   assign wr_ev.present = ev_present;
   assign ev_ready      = !full;
   assign issue         = en && (stage == ST_W'(STAGE_ISSUE)) && !empty;

   sched_fifo #(
      .WIDTH ($bits(event_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ev_valid && ev_ready),
      .wdata (wr_ev),
      .pop   (issue),
      .rdata (head_ev),
      .full  (full),
      .empty (empty),
      .fill  (fill)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage    <= '0;
         out_tick <= 1'b0;
         out_new  <= '0;
         out_data <= '0;
      end else begin
         out_tick <= issue;
         out_new  <= issue ? head_ev.present : '0;
         if (issue) out_data <= head_ev.data;
         if (en) stage <= (stage == ST_W'(NUM_STAGES - 1)) ? '0 : stage + 1'b1;
      end
   end

`ifdef EVENT_SCHED_TIMESTAMP_EN
   logic [63:0] ts_cnt;

   assign wr_ev.ts = ts_cnt;

   // Timestamp is the en-cycle count at push time, presented alongside out_tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         ts_cnt <= '0;
         ev_ts  <= '0;
      end else begin
         if (en)    ts_cnt <= ts_cnt + 64'd1;
         if (issue) ev_ts  <= head_ev.ts;
      end
   end
`endif

endmodule

// File: tb/tb_event_scheduler.sv
// Scoreboard bench for event_scheduler: expected events queued at push, compared at out_tick.
// Build with EVENT_SCHED_TIMESTAMP_EN to also exercise ev_ts.
module tb_event_scheduler;

   localparam int DW = 3 * 64;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           en = 1'b0;
   logic           ev_valid = 1'b0;
   logic           ev_ready;
   logic [DW-1:0]  ev_data = '0;
   logic [2:0]     ev_present = '0;
   logic [DW-1:0]  out_data;
   logic [2:0]     out_new;
   logic           out_tick;
   logic [2:0]     stage;
   logic [3:0]     fill;
`ifdef EVENT_SCHED_TIMESTAMP_EN
   logic [63:0]    ev_ts;
`endif

   typedef struct {
      logic [DW-1:0] data;
      logic [2:0]    present;
      logic [63:0]   ts;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        sb_e;
   int          chk_cnt = 0;
   int          pass_cnt = 0;
   logic [63:0] tb_cyc;

   event_scheduler dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_data    (ev_data),
      .ev_present (ev_present),
      .out_data   (out_data),
      .out_new    (out_new),
      .out_tick   (out_tick),
      .stage      (stage),
      .fill       (fill)
`ifdef EVENT_SCHED_TIMESTAMP_EN
      ,
      .ev_ts      (ev_ts)
`endif
   );

   always #5 clk = ~clk;

   // Reference en-cycle counter used to predict timestamps
   always @(posedge clk) begin
      if (rst) tb_cyc <= '0;
      else if (en) tb_cyc <= tb_cyc + 64'd1;
   end

   // Scoreboard: every out_tick must match the oldest accepted event
   always @(negedge clk) begin
      if (!rst) begin
         if (out_tick) begin
            chk_cnt++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_tick: got out_tick=1 expected no pending event (t=%0t)", $time);
            end else begin
               sb_e = exp_q.pop_front();
               if (out_data !== sb_e.data || out_new !== sb_e.present)
                  $display("FAIL sb_event: got data=%h new=%b expected data=%h new=%b",
                           out_data, out_new, sb_e.data, sb_e.present);
               else if (stage !== 3'd1)
                  $display("FAIL sb_issue_stage: got stage=%0d expected 1", stage);
`ifdef EVENT_SCHED_TIMESTAMP_EN
               else if (ev_ts !== sb_e.ts)
                  $display("FAIL sb_ts: got %0d expected %0d", ev_ts, sb_e.ts);
`endif
               else pass_cnt++;
            end
         end else begin
            chk_cnt++;
            if (out_new !== 3'b000) $display("FAIL idle_new: got %b expected 000", out_new);
            else pass_cnt++;
         end
      end
   end

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1;
      ev_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic wait_stage(input int s);
      for (int k = 0; k < 12 && stage != 3'(s); k++) @(negedge clk);
      chk_cnt++;
      if (stage !== 3'(s)) $display("FAIL wait_stage: got %0d expected %0d", stage, s);
      else pass_cnt++;
   endtask

   // Offer one event at the current negedge; returns one negedge later with ev_valid low
   task automatic push_now(input logic [DW-1:0] d, input logic [2:0] p);
      exp_t e;
      ev_valid = 1'b1;
      ev_data = d;
      ev_present = p;
      if (ev_ready) begin
         e.data = d;
         e.present = p;
         e.ts = tb_cyc;
         exp_q.push_back(e);
      end
      @(negedge clk);
      ev_valid = 1'b0;
   endtask

   task automatic wait_tick(output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!out_tick && k < 20);
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 80 && exp_q.size() != 0; k++) @(negedge clk);
      chk_cnt++;
      if (exp_q.size() != 0) $display("FAIL %s_drain: got %0d pending expected 0", name, exp_q.size());
      else pass_cnt++;
   endtask

   task automatic test_reset;
      logic [2:0] seq [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
      en = 1'b0;
      do_reset();
      chk_cnt++;
      if (stage !== 3'd0 || fill !== 4'd0 || out_tick !== 1'b0 || out_new !== 3'b000 ||
          out_data !== '0 || ev_ready !== 1'b1)
         $display("FAIL reset_state: got stage=%0d fill=%0d tick=%b new=%b ready=%b expected 0 0 0 000 1",
                  stage, fill, out_tick, out_new, ev_ready);
      else pass_cnt++;
`ifdef EVENT_SCHED_TIMESTAMP_EN
      chk_cnt++;
      if (ev_ts !== 64'd0) $display("FAIL reset_ts: got %0d expected 0", ev_ts);
      else pass_cnt++;
`endif
      en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk_cnt++;
         if (stage !== seq[i] || out_tick !== 1'b0 || ev_ready !== 1'b1)
            $display("FAIL stage_cycle[%0d]: got stage=%0d tick=%b ready=%b expected %0d 0 1",
                     i, stage, out_tick, ev_ready, seq[i]);
         else pass_cnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_single_issue;
      logic [2:0]    pres [5] = '{3'b101, 3'b111, 3'b010, 3'b000, 3'b110};
      logic [DW-1:0] d;
      int            k;
      int            want;
      en = 1'b1;
      for (int s = 0; s < 5; s++) begin
         wait_stage(s);
         d = (s == 1) ? {64'd1, 64'd1, 64'd1} : {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         push_now(d, pres[s]);
         want = ((s == 0) ? 5 : 5 - s) + 1;
         k = 1;
         while (!out_tick && k < 12) begin
            @(negedge clk);
            k++;
         end
         chk_cnt++;
         if (k !== want || fill !== 4'd0)
            $display("FAIL latency_s%0d: got %0d cycles fill=%0d expected %0d cycles fill=0", s, k, fill, want);
         else pass_cnt++;
         @(negedge clk);
         chk_cnt++;
         if (out_tick !== 1'b0 || out_data !== d)
            $display("FAIL hold_s%0d: got tick=%b data=%h expected tick=0 data=%h", s, out_tick, out_data, d);
         else pass_cnt++;
      end
      drain("single");
   endtask

   task automatic test_back_to_back;
      int k;
      en = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         chk_cnt++;
         if (ev_ready !== 1'b1 || fill !== 4'(i))
            $display("FAIL fill_up[%0d]: got ready=%b fill=%0d expected 1 %0d", i, ev_ready, fill, i);
         else pass_cnt++;
         push_now({64'(i), 64'(i * 3), 64'hA5A5_0000 + 64'(i)}, 3'(i));
      end
      ev_valid = 1'b1;
      ev_data = {64'd9, 64'd99, 64'd999};
      ev_present = 3'b011;
      chk_cnt++;
      if (ev_ready !== 1'b0 || fill !== 4'd8)
         $display("FAIL full_hold: got ready=%b fill=%0d expected 0 8", ev_ready, fill);
      else pass_cnt++;
      en = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!ev_ready && k < 12);
      chk_cnt++;
      if (ev_ready !== 1'b1 || out_tick !== 1'b1 || fill !== 4'd7)
         $display("FAIL ninth_after_pop: got ready=%b tick=%b fill=%0d expected 1 1 7", ev_ready, out_tick, fill);
      else pass_cnt++;
      exp_q.push_back('{data: {64'd9, 64'd99, 64'd999}, present: 3'b011, ts: tb_cyc});
      @(negedge clk);
      ev_valid = 1'b0;
      chk_cnt++;
      if (fill !== 4'd8) $display("FAIL ninth_push: got fill=%0d expected 8", fill);
      else pass_cnt++;
      for (int t = 0; t < 8; t++) begin
         wait_tick(k);
         chk_cnt++;
         if (k !== ((t == 0) ? 4 : 5)) $display("FAIL rate[%0d]: got %0d cycles expected %0d", t, k, (t == 0) ? 4 : 5);
         else pass_cnt++;
      end
      drain("b2b");
   endtask

   task automatic test_enable_freeze;
      int k;
      en = 1'b1;
      wait_stage(1);
      push_now({64'd11, 64'd22, 64'd33}, 3'b001);
      push_now({64'd44, 64'd55, 64'd66}, 3'b100);
      en = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk_cnt++;
         if (stage !== 3'd3 || out_tick !== 1'b0 || fill !== 4'd2)
            $display("FAIL freeze[%0d]: got stage=%0d tick=%b fill=%0d expected 3 0 2", i, stage, out_tick, fill);
         else pass_cnt++;
      end
      en = 1'b1;
      wait_tick(k);
      chk_cnt++;
      if (k !== 3) $display("FAIL resume_first: got %0d cycles expected 3", k);
      else pass_cnt++;
      wait_tick(k);
      chk_cnt++;
      if (k !== 5) $display("FAIL resume_second: got %0d cycles expected 5", k);
      else pass_cnt++;
      drain("freeze");
   endtask

   task automatic test_reset_mid;
      en = 1'b1;
      wait_stage(1);
      for (int i = 0; i < 4; i++) push_now({64'(i + 100), 64'd7, 64'd8}, 3'b111);
      chk_cnt++;
      if (fill !== 4'd4 || stage !== 3'd0) $display("FAIL pre_reset: got fill=%0d stage=%0d expected 4 0", fill, stage);
      else pass_cnt++;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk_cnt++;
      if (fill !== 4'd0 || stage !== 3'd0 || out_new !== 3'b000 || out_tick !== 1'b0 ||
          out_data !== '0 || ev_ready !== 1'b1)
         $display("FAIL mid_reset: got fill=%0d stage=%0d new=%b tick=%b ready=%b expected 0 0 000 0 1",
                  fill, stage, out_new, out_tick, ev_ready);
      else pass_cnt++;
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk_cnt++;
         if (out_tick !== 1'b0 || fill !== 4'd0)
            $display("FAIL stale_issue[%0d]: got tick=%b fill=%0d expected 0 0", i, out_tick, fill);
         else pass_cnt++;
      end
   endtask

`ifdef EVENT_SCHED_TIMESTAMP_EN
   task automatic test_timestamp;
      int k;
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 20 && tb_cyc != 64'd12; i++) @(negedge clk);
      push_now({64'd1, 64'd2, 64'd3}, 3'b111);
      push_now({64'd4, 64'd5, 64'd6}, 3'b111);
      wait_tick(k);
      chk_cnt++;
      if (ev_ts !== 64'd12) $display("FAIL ts_first: got %0d expected 12", ev_ts);
      else pass_cnt++;
      wait_tick(k);
      chk_cnt++;
      if (ev_ts !== 64'd13) $display("FAIL ts_second: got %0d expected 13", ev_ts);
      else pass_cnt++;
      drain("ts");
   endtask
`endif

   initial begin
      test_reset();
      test_single_issue();
      test_back_to_back();
      test_enable_freeze();
      test_reset_mid();
`ifdef EVENT_SCHED_TIMESTAMP_EN
      test_timestamp();
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no completion expected summary before 500000");
      $fatal(1, "timeout");
   end

endmodule
